// File: rtl/radix_bist_sequencer_if.sv
// Handshake between the BIST sequencer (master) and the radix-4 multiplier (slave).
interface radix_bist_sequencer_if;
    logic        mul_start;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic        mul_ready;
    logic [15:0] mul_result;

    modport master (output mul_start, mul_x, mul_y, input mul_ready, mul_result);
    modport slave  (input mul_start, mul_x, mul_y, output mul_ready, mul_result);
endinterface

// File: rtl/radix_bist_sequencer.sv
// LFSR-driven self-test sequencer for the 8x8 multiplier: drives vectors, checks
// each product against a golden multiply and compacts results into a MISR.
module radix_bist_sequencer #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned TIMEOUT = 64,
    parameter bit          SIGNED  = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          bist_go_i,
    input  logic                          abort_i,
    input  logic [7:0]                    num_vectors_i,
    radix_bist_sequencer_if.master        mul_if,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          timeout_o,
    output logic [7:0]                    err_count_o,
    output logic [7:0]                    fail_x_o,
    output logic [7:0]                    fail_y_o,
    output logic [15:0]                   signature_o
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [15:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] lfsr_q, sig_q, timer_q;
    logic [7:0]  cnt_q, vec_q, err_q, fx_q, fy_q, x_q, y_q;
    logic        start_q, busy_q, done_q, pass_q, tmo_q;

    logic signed [15:0] prod_s;
    logic [15:0] prod_u, golden, lfsr_d, sig_d;
    logic [7:0]  err_d, vec_d;
    logic        mismatch;

    always_comb begin
        prod_s   = $signed({{8{x_q[7]}}, x_q}) * $signed({{8{y_q[7]}}, y_q});
        prod_u   = {8'd0, x_q} * {8'd0, y_q};
        golden   = SIGNED ? $unsigned(prod_s) : prod_u;
        mismatch = (mul_if.mul_result != golden);
        err_d    = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        vec_d    = vec_q + 8'd1;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
        sig_d    = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ mul_if.mul_result;
    end

    // Operands are loaded on entry to START so they are already stable in that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            sig_q   <= '0;
            timer_q <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (abort_i) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (bist_go_i) begin
                            lfsr_q <= SEED_EFF;
                            cnt_q  <= num_vectors_i;
                            vec_q  <= '0;
                            err_q  <= '0;
                            fx_q   <= '0;
                            fy_q   <= '0;
                            sig_q  <= '0;
                            tmo_q  <= 1'b0;
                            if (num_vectors_i == '0) begin
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= 1'b1;
                            end else begin
                                state_q <= S_START;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b0;
                                pass_q  <= 1'b0;
                                start_q <= 1'b1;
                                x_q     <= SEED_EFF[15:8];
                                y_q     <= SEED_EFF[7:0];
                            end
                        end
                    end
                    S_START: begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                    S_WAIT: begin
                        timer_q <= timer_q + 16'd1;
                        // The first WAIT cycle ignores ready to mask a stale flag.
                        if (timer_q != '0 && mul_if.mul_ready) begin
                            state_q <= S_CHECK;
                        end else if (timer_q == TMO_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b0;
                            tmo_q   <= 1'b1;
                        end
                    end
                    S_CHECK: begin
                        err_q  <= err_d;
                        sig_q  <= sig_d;
                        lfsr_q <= lfsr_d;
                        vec_q  <= vec_d;
                        if (mismatch && err_q == '0) begin
                            fx_q <= x_q;
                            fy_q <= y_q;
                        end
                        if (vec_d == cnt_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                            x_q     <= lfsr_d[15:8];
                            y_q     <= lfsr_d[7:0];
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mul_if.mul_start = start_q;
    assign mul_if.mul_x     = x_q;
    assign mul_if.mul_y     = y_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = tmo_q;
    assign err_count_o      = err_q;
    assign fail_x_o         = fx_q;
    assign fail_y_o         = fy_q;
    assign signature_o      = sig_q;

endmodule

// File: tb/tb_radix_bist_sequencer.sv
// Randomized bench for radix_bist_sequencer: behavioural multiplier plus a run-level
// model of operands, error count, first failure and MISR signature.
module tb_radix_bist_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, go, abort;
    logic [7:0]  nvec;
    logic        busy, done, pass, tmo;
    logic [7:0]  err, fx, fy;
    logic [15:0] sig;

    radix_bist_sequencer_if mif();

    radix_bist_sequencer #(.SEED(16'hACE1), .TIMEOUT(64), .SIGNED(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bist_go_i(go), .abort_i(abort),
        .num_vectors_i(nvec), .mul_if(mif),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_count_o(err), .fail_x_o(fx), .fail_y_o(fy), .signature_o(sig)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int starts = 0, run_base = 0, exp_starts = 0;
    int cyc_now = 0, t_first_start = 0, t_done = 0;
    int age = -1, dly = 1, vidx = 0, cmp_k = 0;
    int n_r, s0;
    logic [7:0]  ex [0:255];
    logic [7:0]  ey [0:255];
    bit          fault_v [0:255];
    bit          to_mode = 1'b0;
    logic [7:0]  exp_err, exp_fx, exp_fy;
    logic [15:0] exp_sig;
    bit          exp_pass, exp_tmo;

    always @(posedge clk) cyc_now <= cyc_now + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] mult_ref(input logic [7:0] a, input logic [7:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[15:0];
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) fault_v[i] = 1'b0;
    endtask

    // Expected outcome of a whole run, from the operand sequence and product rule.
    task automatic plan(input int n);
        logic [15:0] l, r;
        int e;
        l = 16'hACE1; e = 0; exp_sig = '0; exp_fx = '0; exp_fy = '0;
        for (int i = 0; i < n; i++) begin
            ex[i] = l[15:8];
            ey[i] = l[7:0];
            r = mult_ref(ex[i], ey[i]) ^ {15'd0, fault_v[i]};
            if (fault_v[i]) begin
                if (e == 0) begin exp_fx = ex[i]; exp_fy = ey[i]; end
                e++;
            end
            exp_sig = {exp_sig[14:0], exp_sig[15] ^ exp_sig[14] ^ exp_sig[12] ^ exp_sig[3]} ^ r;
            l = lfsr_step(l);
        end
        if (to_mode) begin
            exp_starts = (n > 0) ? 1 : 0;
            exp_err = '0; exp_sig = '0; exp_fx = '0; exp_fy = '0;
            exp_pass = 1'b0; exp_tmo = 1'b1;
        end else begin
            exp_starts = n;
            exp_err = (e > 255) ? 8'hFF : 8'(e);
            exp_pass = (e == 0);
            exp_tmo = 1'b0;
        end
    endtask

    // Behavioural multiplier: possibly-stale ready in the first WAIT cycle, then 1..4 cycles latency.
    initial begin
        mif.mul_ready = 1'b0;
        mif.mul_result = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mif.mul_ready = 1'b0;
                age = -1;
            end else if (mif.mul_start) begin
                age = 0;
                dly = $urandom_range(1, 4);
                vidx = starts - run_base;
            end else if (age >= 0) begin
                age++;
                if (age == 1) begin
                    mif.mul_ready = 1'($urandom_range(0, 1));
                    mif.mul_result = 16'($urandom);
                end else if (to_mode || age < 1 + dly) begin
                    mif.mul_ready = 1'b0;
                end else begin
                    mif.mul_ready = 1'b1;
                    mif.mul_result = mult_ref(mif.mul_x, mif.mul_y) ^ {15'd0, fault_v[vidx]};
                end
            end
        end
    end

    // Per-cycle compare: every start carries the model's operands, which then hold while busy.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mif.mul_start) begin
                cmp_k = starts - run_base;
                chk("start_within_run", 64'(cmp_k < exp_starts), 64'd1);
                if (cmp_k < exp_starts) chk("start_operands", 64'({mif.mul_x, mif.mul_y}), 64'({ex[cmp_k], ey[cmp_k]}));
                if (cmp_k == 0) t_first_start = cyc_now;
                starts++;
            end else if (rst_n && busy && starts > run_base) begin
                cmp_k = starts - run_base - 1;
                if (cmp_k < exp_starts) chk("operands_held", 64'({mif.mul_x, mif.mul_y}), 64'({ex[cmp_k], ey[cmp_k]}));
            end
        end
    end

    task automatic pulse_go(input logic [7:0] n);
        @(posedge clk); #1;
        nvec = n;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < max_cyc);
        t_done = cyc_now;
        chk("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic run(input int n, input int budget);
        plan(n);
        run_base = starts;
        pulse_go(8'(n));
        if (n > 0) pulse_go(8'(n + 3));
        wait_done(budget);
    endtask

    task automatic final_checks(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        chk({tag, "_timeout"}, 64'(tmo), 64'(exp_tmo));
        chk({tag, "_err_count"}, 64'(err), 64'(exp_err));
        chk({tag, "_fail_xy"}, 64'({fx, fy}), 64'({exp_fx, exp_fy}));
        chk({tag, "_signature"}, 64'(sig), 64'(exp_sig));
        chk({tag, "_start_count"}, 64'(starts - run_base), 64'(exp_starts));
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; nvec = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, pass, tmo, err, fx, fy, sig, mif.mul_start, mif.mul_x, mif.mul_y}), 64'd0);
        rst_n = 1'b1;

        run(1, 40);
        final_checks("single");
        chk("single_sig_literal", 64'(sig), 64'h0A2C);
        chk("single_ops_literal", 64'({mif.mul_x, mif.mul_y}), 64'h0000ACE1);

        fault_v[3] = 1'b1;
        run(16, 300);
        final_checks("fault16");
        chk("fault16_err_literal", 64'(err), 64'd1);
        clear_faults();

        repeat (5) begin
            n_r = $urandom_range(1, 20);
            for (int i = 0; i < n_r; i++) fault_v[i] = ($urandom_range(0, 3) == 0);
            run(n_r, 10 * n_r + 40);
            final_checks("random");
            clear_faults();
        end

        to_mode = 1'b1;
        run(5, 200);
        final_checks("timeout");
        chk("timeout_wait_cycles", 64'(t_done - t_first_start), 64'd65);
        to_mode = 1'b0;

        run(0, 5);
        final_checks("zero");
        chk("zero_done_next_cycle", 64'(t_done - cyc_now), 64'd0);
        chk("zero_pass_literal", 64'({done, pass}), 64'b11);

        plan(10);
        run_base = starts;
        pulse_go(8'd10);
        pulse_go(8'd3);
        s0 = 0;
        while ((starts - run_base) < 5 && s0 < 200) begin @(negedge clk); s0++; end
        chk("abort_reached_vector5", 64'(starts - run_base), 64'd5);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        @(negedge clk);
        chk("abort_flags", 64'({busy, done, pass, mif.mul_start}), 64'd0);
        plan(4);
        chk("abort_sig_retained", 64'(sig), 64'(exp_sig));
        chk("abort_err_retained", 64'(err), 64'd0);
        s0 = starts;
        repeat (10) @(negedge clk);
        chk("abort_no_start", 64'(starts - s0), 64'd0);
        run(10, 200);
        final_checks("restart");

        plan(5);
        run_base = starts;
        pulse_go(8'd5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", 64'({busy, done, pass, tmo, err, fx, fy, sig, mif.mul_start, mif.mul_x, mif.mul_y}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = starts;
        repeat (10) @(negedge clk);
        chk("reset_no_start", 64'(starts - s0), 64'd0);
        chk("reset_idle_flags", 64'({busy, done}), 64'd0);

        run(3, 60);
        final_checks("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit actual=expired required=finished");
        $fatal(1);
    end

endmodule

// File: doc/radix_bist_sequencer.md
Name: radix_bist_sequencer

Overview:
- Self-test sequencer for the radix-4 multiplier datapath.
- Generates pseudo-random 8-bit operand pairs from an internal 16-bit LFSR and drives one start pulse per vector. Waits for the multiplier's ready, checks the 16-bit result against a built-in golden product, and compacts results into a 16-bit MISR signature.
- Sits between the test-enable logic and the multiplier's start/x/y inputs; reports busy/done/pass, error count and the first failing operand pair.

Parameters:
- SEED, 16'hACE1, LFSR load value at run start; a value of 0 is replaced by 16'h0001.
- TIMEOUT, 64, maximum WAIT-state cycles per vector before the run aborts with timeout.
- SIGNED, 1, 1 = golden product is signed(x)*signed(y); 0 = unsigned; result is 16 bits in both cases.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bist_go  in  1  start-run request, sampled only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE.
- num_vectors  in  8  vectors per run, latched on go.
- mul_ready  in  1  multiplier ready/done flag.
- mul_result  in  16  multiplier product.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_x  out  8  operand x, held stable from START through CHECK.
- mul_y  out  8  operand y, held stable from START through CHECK.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next go or abort.
- pass  out  1  valid when done: err_count==0 and no timeout.
- timeout  out  1  run ended by timeout.
- err_count  out  8  mismatching vectors, saturating at 255.
- fail_x  out  8  x of the first mismatch.
- fail_y  out  8  y of the first mismatch.
- signature  out  16  MISR value.

Behaviour:
- Reset values: all outputs, state, LFSR, MISR and counters are 0; state = IDLE.
- States: IDLE, START, WAIT, CHECK, DONE.
- IDLE/DONE + bist_go:
  - load lfsr=SEED (or 1 if SEED==0); latch num_vectors.
  - clear vec_cnt, err_count, fail_x/y, signature, timeout, done, pass.
  - if the latched count is 0: go to DONE with pass=1; else go to START with busy=1.
- START:
  - mul_x=lfsr[15:8], mul_y=lfsr[7:0]; mul_start=1 for exactly this cycle.
  - Next state WAIT, timer=0.
- WAIT:
  - timer increments every cycle.
  - mul_ready is ignored in the first WAIT cycle (masks stale ready from the previous vector); from timer>=1, mul_ready=1 moves to CHECK.
  - If timer reaches TIMEOUT-1 without an accepted ready: go to DONE with timeout=1, pass=0; the vector is not counted.
- CHECK (one cycle):
  - golden = SIGNED ? signed 8x8 product : unsigned 8x8 product, truncated to 16 bits.
  - Mismatch: err_count+1 (saturating). If err_count was 0, capture fail_x/fail_y.
  - MISR: signature <= {signature[14:0], signature[15]^signature[14]^signature[12]^signature[3]} ^ mul_result.
  - LFSR: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[14]^lfsr[12]^lfsr[3]}.
  - vec_cnt+1; if it equals the latched count go to DONE, else go to START.
- DONE: busy=0, done=1, pass=(err_count==0)&&!timeout. Outputs hold until bist_go (new run) or abort.
- Per-vector latency: 1 (START) + WAIT cycles (minimum 2) + 1 (CHECK).
- bist_go while busy is ignored; num_vectors changes mid-run have no effect.
- abort has priority over every transition: next state IDLE, busy=0, done=0, pass=0, mul_start=0; err_count and signature are retained.
- reset asserted mid-run: immediate return to reset values, no further mul_start.

Test Plan:
- Reset: assert reset=0 mid-WAIT -> all outputs 0 immediately, no mul_start after release until bist_go.
- Single vector, SEED=ACE1, SIGNED=1, correct model: num_vectors=1 -> mul_x=8'hAC, mul_y=8'hE1, exactly one mul_start; done=1, pass=1, err_count=0, signature=16'h0A2C.
- Multi-run with fault: num_vectors=16, model returns result^16'h0001 on vector index 3 only -> err_count=1, fail_x/fail_y = the LFSR operands of vector 3, pass=0, exactly 16 mul_start pulses.
- Timeout: mul_ready held 0 after the first start -> done=1, timeout=1, pass=0 after TIMEOUT WAIT cycles; no second mul_start.
- Zero vectors: num_vectors=0, bist_go -> done=1 and pass=1 next cycle, no mul_start, signature=0.
- Abort and ignored go: pulse bist_go again while busy (no effect), then abort during vector 5 -> IDLE, busy=0, done=0; a new bist_go restarts from SEED with identical operands.
